// File: rtl/fetch_prefetch.sv
// fetch_prefetch: prefetching instruction fetch unit.
//
// Keeps a DEPTH-entry FIFO of {addr, instr} pairs filled with sequential
// instructions ahead of the core PC, so sequential PC steps are served with no
// RAM round trip. Any PC that does not match the buffer head (or the single
// in-flight read when the buffer is empty) flushes the buffer and redirects
// fetch to that PC. All state updates on the falling clock edge.
//
// Ports:
//   clk            core clock (state updates on negedge)
//   rst_n          asynchronous active-low reset
//   pc_in          current core PC
//   flag_boot_mode boot loader owns RAM; fetch frozen and flushed
//   ram_data       RAM read data
//   ram_busy       RAM cannot accept a command
//   ram_cack       RAM accepted the pending command
//   ram_data_ready ram_data valid for the in-flight read
//   ram_read       read command strobe
//   ram_addr       read address
//   ram_addr_ovr   fetch owns the RAM address bus
//   instr_out      instruction for pc_in, NOP_INSTR while stalled
//   pc_hold        stall request to the core
module fetch_prefetch #(
  parameter int unsigned        ADDR_W    = 16,
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        DEPTH     = 4,
  parameter int unsigned        PC_STEP   = 1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               flag_boot_mode,
  input  logic [INSTR_W-1:0] ram_data,
  input  logic               ram_busy,
  input  logic               ram_cack,
  input  logic               ram_data_ready,
  output logic               ram_read,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_addr_ovr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               pc_hold
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e             st_q, st_d;
  logic [ADDR_W-1:0]  prev_pc_q, prev_pc_d;
  logic               first_q, first_d;
  logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
  logic               stale_q, stale_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               ram_read_q, ram_read_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic               ram_ovr_q, ram_ovr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               hold_q, hold_d;

  logic [ADDR_W-1:0]  buf_addr_q  [DEPTH];
  logic [INSTR_W-1:0] buf_instr_q [DEPTH];
  logic               buf_we;

  logic demand, in_flight, ret, ret_ok, buf_empty;
  logic hit_buf, hit_ret, wait_fl, redirect, bypass, push, pop;

  always_comb begin
    // ram_addr_q holds the in-flight read address while in StReq/StWait.
    demand    = first_q || (pc_in != prev_pc_q);
    in_flight = (st_q != StIdle);
    ret       = (st_q == StWait) && ram_data_ready;
    ret_ok    = ret && !stale_q;
    buf_empty = (cnt_q == '0);

    hit_buf  = demand && !buf_empty && (buf_addr_q[rd_ptr_q] == pc_in);
    // With an empty buffer the returning word acts as the head entry.
    hit_ret  = demand && buf_empty && ret_ok && (ram_addr_q == pc_in);
    wait_fl  = demand && buf_empty && in_flight && !ret && !stale_q && (ram_addr_q == pc_in);
    redirect = demand && !hit_buf && !hit_ret && !wait_fl;
    // A stalled demand is satisfied directly from the returning read.
    bypass   = !demand && hold_q && ret_ok && (ram_addr_q == pc_in);
    pop      = hit_buf;
    push     = ret_ok && !hit_ret && !bypass && !redirect;
  end

  always_comb begin
    st_d         = st_q;
    prev_pc_d    = pc_in;
    first_d      = 1'b0;
    fetch_addr_d = fetch_addr_q;
    stale_d      = stale_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    ram_read_d   = ram_read_q;
    ram_addr_d   = ram_addr_q;
    ram_ovr_d    = ram_ovr_q;
    instr_d      = instr_q;
    hold_d       = hold_q;
    buf_we       = 1'b0;

    if (flag_boot_mode) begin
      // Abandon everything; the current PC is refetched once boot mode ends.
      st_d       = StIdle;
      first_d    = 1'b1;
      stale_d    = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      cnt_d      = '0;
      ram_read_d = 1'b0;
      ram_ovr_d  = 1'b0;
      hold_d     = 1'b0;
      instr_d    = NOP_INSTR;
    end else begin
      if (hit_buf) begin
        instr_d = buf_instr_q[rd_ptr_q];
        hold_d  = 1'b0;
      end else if (hit_ret || bypass) begin
        instr_d = ram_data;
        hold_d  = 1'b0;
      end else if (wait_fl || redirect) begin
        instr_d = NOP_INSTR;
        hold_d  = 1'b1;
      end

      if (ret) stale_d = 1'b0;

      if (redirect) begin
        rd_ptr_d     = '0;
        wr_ptr_d     = '0;
        cnt_d        = '0;
        fetch_addr_d = pc_in;
        // A read still on the bus completes but its data is dropped.
        if (in_flight && !ret) stale_d = 1'b1;
      end else begin
        if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        cnt_d = cnt_q + CntW'(push) - CntW'(pop);
        if (ret_ok) fetch_addr_d = fetch_addr_q + ADDR_W'(PC_STEP);
      end

      unique case (st_q)
        StIdle: begin
          // Nothing in flight here, so occupancy is the post-edge entry count.
          if ((cnt_d < CntW'(DEPTH)) && !ram_busy) begin
            ram_read_d = 1'b1;
            ram_ovr_d  = 1'b1;
            ram_addr_d = fetch_addr_d;
            st_d       = StReq;
          end else begin
            ram_read_d = 1'b0;
            ram_ovr_d  = 1'b0;
          end
        end
        StReq: begin
          if (ram_cack) begin
            ram_read_d = 1'b0;
            st_d       = StWait;
          end
        end
        StWait: begin
          if (ram_data_ready) st_d = StIdle;
        end
        default: st_d = StIdle;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= StIdle;
      prev_pc_q    <= '0;
      first_q      <= 1'b1;
      fetch_addr_q <= '0;
      stale_q      <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      ram_read_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_ovr_q    <= 1'b0;
      instr_q      <= NOP_INSTR;
      hold_q       <= 1'b0;
    end else begin
      st_q         <= st_d;
      prev_pc_q    <= prev_pc_d;
      first_q      <= first_d;
      fetch_addr_q <= fetch_addr_d;
      stale_q      <= stale_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      ram_read_q   <= ram_read_d;
      ram_addr_q   <= ram_addr_d;
      ram_ovr_q    <= ram_ovr_d;
      instr_q      <= instr_d;
      hold_q       <= hold_d;
    end
  end

  // Buffer storage is data only; validity lives in the pointers and count.
  always_ff @(negedge clk) begin
    if (buf_we) begin
      buf_addr_q[wr_ptr_q]  <= ram_addr_q;
      buf_instr_q[wr_ptr_q] <= ram_data;
    end
  end

  assign ram_read     = ram_read_q;
  assign ram_addr     = ram_addr_q;
  assign ram_addr_ovr = ram_ovr_q;
  assign instr_out    = instr_q;
  assign pc_hold      = hold_q;

endmodule
